// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe
//   Pipelined multi-mode barrel shifter: ROL, ROR, SLL, SRL, SRA and pass-through.
//   One register stage per shift level. Stage i shifts by 2**i when amt bit i is set.
//   A result appears on out_valid ADDRESS_BITS clock edges after the edge that
//   accepts the operand, counting that edge, provided there are no stalls.
//   Back-pressure freezes the whole pipe. Empty stages are not squeezed out.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   in_valid     operand present             in_ready     pipe can accept this cycle
//   in_op        0 ROL 1 ROR 2 SLL 3 SRL 4 SRA, others pass-through
//   in_amt       shift amount, 0..WIDTH-1
//   in_num       operand
//   out_valid    result present              out_ready    downstream accepts result
//   out_shifted  result                      out_carry    last bit shifted out (shifts only)
//   out_zero     out_shifted == 0
module barrel_shift_pipe #(
    parameter int ADDRESS_BITS = 3,
    parameter int OP_BITS      = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OP_BITS-1:0]           in_op,
    input  logic [ADDRESS_BITS-1:0]      in_amt,
    input  logic [(1<<ADDRESS_BITS)-1:0] in_num,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [(1<<ADDRESS_BITS)-1:0] out_shifted,
    output logic                         out_carry,
    output logic                         out_zero
);
    localparam int WIDTH = 1 << ADDRESS_BITS;

    localparam logic [OP_BITS-1:0] OP_ROL = OP_BITS'(0);
    localparam logic [OP_BITS-1:0] OP_ROR = OP_BITS'(1);
    localparam logic [OP_BITS-1:0] OP_SLL = OP_BITS'(2);
    localparam logic [OP_BITS-1:0] OP_SRL = OP_BITS'(3);
    localparam logic [OP_BITS-1:0] OP_SRA = OP_BITS'(4);

    // Index 0 carries the input port. Index i+1 carries the register of stage i.
    logic [WIDTH-1:0]        data_s  [ADDRESS_BITS+1];
    logic [OP_BITS-1:0]      op_s    [ADDRESS_BITS+1];
    logic [ADDRESS_BITS-1:0] amt_s   [ADDRESS_BITS+1];
    logic                    carry_s [ADDRESS_BITS+1];
    logic                    sign_s  [ADDRESS_BITS+1];
    logic                    valid_s [ADDRESS_BITS+1];

    logic stall;

    assign stall    = valid_s[ADDRESS_BITS] & ~out_ready;
    assign in_ready = ~stall;

    assign data_s[0]  = in_num;
    assign op_s[0]    = in_op;
    assign amt_s[0]   = in_amt;
    assign carry_s[0] = 1'b0;
    // The SRA fill comes from the operand MSB captured on entry. The stages do not re-read it.
    assign sign_s[0]  = in_num[WIDTH-1];
    assign valid_s[0] = in_valid;

    for (genvar i = 0; i < ADDRESS_BITS; i++) begin : g_stage
        localparam int SH = 1 << i;

        logic [WIDTH-1:0]        data_d,  data_q;
        logic [OP_BITS-1:0]      op_d,    op_q;
        logic [ADDRESS_BITS-1:0] amt_d,   amt_q;
        logic                    carry_d, carry_q;
        logic                    sign_d,  sign_q;
        logic                    valid_d, valid_q;
        logic                    spill_hi, spill_lo;

        // These are the last bits to leave the word for a left or right shift by SH at this level.
        assign spill_hi = data_s[i][WIDTH-SH];
        assign spill_lo = data_s[i][SH-1];

        always_comb begin
            data_d  = data_q;
            op_d    = op_q;
            amt_d   = amt_q;
            carry_d = carry_q;
            sign_d  = sign_q;
            valid_d = valid_q;
            if (!stall) begin
                valid_d = valid_s[i];
                if (valid_s[i]) begin
                    data_d  = data_s[i];
                    op_d    = op_s[i];
                    amt_d   = amt_s[i];
                    carry_d = carry_s[i];
                    sign_d  = sign_s[i];
                    if (amt_s[i][i]) begin
                        case (op_s[i])
                            OP_ROL: data_d = (data_s[i] << SH) | (data_s[i] >> (WIDTH - SH));
                            OP_ROR: data_d = (data_s[i] >> SH) | (data_s[i] << (WIDTH - SH));
                            OP_SLL: begin
                                data_d  = data_s[i] << SH;
                                carry_d = spill_hi;
                            end
                            OP_SRL: begin
                                data_d  = data_s[i] >> SH;
                                carry_d = spill_lo;
                            end
                            OP_SRA: begin
                                data_d  = (data_s[i] >> SH) | ({WIDTH{sign_s[i]}} << (WIDTH - SH));
                                carry_d = spill_lo;
                            end
                            default: data_d = data_s[i];
                        endcase
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q  <= '0;
                op_q    <= '0;
                amt_q   <= '0;
                carry_q <= 1'b0;
                sign_q  <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                op_q    <= op_d;
                amt_q   <= amt_d;
                carry_q <= carry_d;
                sign_q  <= sign_d;
                valid_q <= valid_d;
            end
        end

        assign data_s[i+1]  = data_q;
        assign op_s[i+1]    = op_q;
        assign amt_s[i+1]   = amt_q;
        assign carry_s[i+1] = carry_q;
        assign sign_s[i+1]  = sign_q;
        assign valid_s[i+1] = valid_q;
    end

    assign out_valid   = valid_s[ADDRESS_BITS];
    assign out_shifted = data_s[ADDRESS_BITS];
    assign out_carry   = carry_s[ADDRESS_BITS];
    assign out_zero    = (data_s[ADDRESS_BITS] == '0);

    // The last stage keeps op, amt and sign like every other stage, but nothing downstream reads them.
    logic unused_tail;
    assign unused_tail = ^{op_s[ADDRESS_BITS], amt_s[ADDRESS_BITS], sign_s[ADDRESS_BITS]};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Testbench for barrel_shift_pipe.
// It builds three instances with ADDRESS_BITS = 1, 3 and 5. All three receive the directed stimulus.
// The detailed directed checks look at the ADDRESS_BITS = 3 instance.
// After that, each instance runs its own randomised traffic with random back-pressure.
// Every instance has a reference model: a queue of expected results that each carry an age.
module tb_barrel_shift_pipe;

    typedef struct {
        logic [31:0] res;
        logic        carry;
        int          age;
    } item_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic       d_valid, d_ready;
    logic [2:0] d_op, d_amt;
    logic [7:0] d_num;
    logic       rnd_phase;

    logic        t_out_valid   [3];
    logic        t_in_ready    [3];
    logic        t_out_carry   [3];
    logic        t_out_zero    [3];
    logic [31:0] t_out_shifted [3];

    function automatic void check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference model. It works on a plain integer word of w bits and returns {carry, result}.
    function automatic logic [32:0] ref_op(input int w, input int op, input int k, input longint n_in);
        longint mask, n, r, s;
        logic   c;
        mask = (longint'(1) << w) - 1;
        n    = n_in & mask;
        r    = n;
        c    = 1'b0;
        case (op)
            0: r = ((n << k) | (n >> (w - k))) & mask;
            1: r = ((n >> k) | (n << (w - k))) & mask;
            2: begin
                r = (n << k) & mask;
                if (k > 0) c = ((n >> (w - k)) & 1) != 0;
            end
            3: begin
                r = n >> k;
                if (k > 0) c = ((n >> (k - 1)) & 1) != 0;
            end
            4: begin
                s = (((n >> (w - 1)) & 1) != 0) ? n - (longint'(1) << w) : n;
                r = (s >>> k) & mask;
                if (k > 0) c = ((n >> (k - 1)) & 1) != 0;
            end
            default: r = n;
        endcase
        return {c, r[31:0]};
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_inst
        localparam int AB = (k == 0) ? 1 : ((k == 1) ? 3 : 5);
        localparam int W  = 1 << AB;

        logic          in_valid, in_ready, out_valid, out_ready, out_carry, out_zero;
        logic [2:0]    in_op;
        logic [AB-1:0] in_amt;
        logic [W-1:0]  in_num, out_shifted;

        logic          r_valid, r_ready;
        logic [2:0]    r_op;
        logic [AB-1:0] r_amt;
        logic [W-1:0]  r_num;

        item_t q[$];

        assign in_valid  = rnd_phase ? r_valid : d_valid;
        assign in_op     = rnd_phase ? r_op    : d_op;
        assign in_amt    = rnd_phase ? r_amt   : AB'(d_amt);
        assign in_num    = rnd_phase ? r_num   : W'(d_num);
        assign out_ready = rnd_phase ? r_ready : d_ready;

        barrel_shift_pipe #(.ADDRESS_BITS(AB), .OP_BITS(3)) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid    (in_valid),
            .in_ready    (in_ready),
            .in_op       (in_op),
            .in_amt      (in_amt),
            .in_num      (in_num),
            .out_valid   (out_valid),
            .out_ready   (out_ready),
            .out_shifted (out_shifted),
            .out_carry   (out_carry),
            .out_zero    (out_zero)
        );

        assign t_out_valid[k]   = out_valid;
        assign t_in_ready[k]    = in_ready;
        assign t_out_carry[k]   = out_carry;
        assign t_out_zero[k]    = out_zero;
        assign t_out_shifted[k] = 32'(out_shifted);

        // Checking happens on the falling edge. The model is then advanced to the state that follows the next rising edge.
        always @(negedge clk) begin : mon
            bit    exp_v, stall_m;
            item_t it;
            if (!rst_n) begin
                q.delete();
                check($sformatf("w%0d rst out_valid", W), out_valid, 0);
                check($sformatf("w%0d rst out_shifted", W), out_shifted, 0);
                check($sformatf("w%0d rst out_carry", W), out_carry, 0);
                check($sformatf("w%0d rst out_zero", W), out_zero, 1);
                check($sformatf("w%0d rst in_ready", W), in_ready, 1);
            end else begin
                exp_v   = (q.size() > 0) && (q[0].age == AB);
                stall_m = exp_v && !out_ready;
                check($sformatf("w%0d out_valid", W), out_valid, exp_v);
                check($sformatf("w%0d in_ready", W), in_ready, !stall_m);
                if (exp_v) begin
                    check($sformatf("w%0d out_shifted", W), out_shifted, q[0].res);
                    check($sformatf("w%0d out_carry", W), out_carry, q[0].carry);
                    check($sformatf("w%0d out_zero", W), out_zero, q[0].res == 0);
                end
                if (!stall_m) begin
                    if (exp_v) void'(q.pop_front());
                    for (int j = 0; j < q.size(); j++) q[j].age = q[j].age + 1;
                    if (in_valid) begin
                        {it.carry, it.res} = ref_op(W, int'(in_op), int'(in_amt), longint'(in_num));
                        it.age = 1;
                        q.push_back(it);
                    end
                end
            end
        end

        initial begin : drv
            r_valid = 1'b0;
            r_ready = 1'b1;
            r_op    = '0;
            r_amt   = '0;
            r_num   = '0;
            wait (rnd_phase);
            repeat (800) begin
                @(posedge clk);
                #1;
                r_valid = ($urandom_range(0, 3) != 0);
                r_op    = 3'($urandom_range(0, 7));
                r_amt   = AB'($urandom);
                r_num   = W'($urandom);
                r_ready = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk);
            #1;
            r_valid = 1'b0;
            r_ready = 1'b1;
            repeat (AB + 4) @(posedge clk);
            #1;
            check($sformatf("w%0d drained", W), q.size(), 0);
        end
    end

    task automatic run_one(input string name, input int op, input int amt, input int num,
                           input longint exp_res, input longint exp_c);
        int lat;
        d_valid = 1'b1;
        d_op    = 3'(op);
        d_amt   = 3'(amt);
        d_num   = 8'(num);
        d_ready = 1'b1;
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        lat = 1;
        while (!t_out_valid[1] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, lat, 3);
        check({name, " data"}, t_out_shifted[1], exp_res);
        check({name, " carry"}, t_out_carry[1], exp_c);
        check({name, " zero"}, t_out_zero[1], exp_res == 0);
    endtask

    int          bp_op  [5] = '{0, 2, 3, 4, 1};
    int          bp_amt [5] = '{1, 3, 4, 7, 2};
    logic [7:0]  bp_num [5] = '{8'h96, 8'h81, 8'h7F, 8'h01, 8'hC3};
    logic [31:0] bp_exp [5];
    logic [31:0] bp_got [5];

    initial begin
        int n_in, n_out, hold, nr;
        bit seen;
        logic [32:0] rv;

        rst_n     = 1'b0;
        d_valid   = 1'b0;
        d_ready   = 1'b1;
        d_op      = '0;
        d_amt     = '0;
        d_num     = '0;
        rnd_phase = 1'b0;

        // These literal values pin the reference model.
        check("pin rol3",  ref_op(8, 0, 3, 'h96), 33'h0_0000_00B4);
        check("pin ror3",  ref_op(8, 1, 3, 'h96), 33'h0_0000_00D2);
        check("pin sll1",  ref_op(8, 2, 1, 'h96), 33'h1_0000_002C);
        check("pin srl2",  ref_op(8, 3, 2, 'h96), 33'h1_0000_0025);
        check("pin sra2",  ref_op(8, 4, 2, 'h96), 33'h1_0000_00E5);
        check("pin srl7",  ref_op(8, 3, 7, 'h80), 33'h0_0000_0001);
        check("pin sll4",  ref_op(8, 2, 4, 'h80), 33'h0_0000_0000);
        check("pin w2rol", ref_op(2, 0, 1, 'h2),  33'h0_0000_0001);
        check("pin w32sra", ref_op(32, 4, 31, 'h8000_0000), 33'h0_FFFF_FFFF);

        #12;
        check("reset out_valid", t_out_valid[1], 0);
        check("reset out_shifted", t_out_shifted[1], 0);
        check("reset out_zero", t_out_zero[1], 1);
        check("reset in_ready", t_in_ready[1], 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_one("rol3",  0, 3, 'h96, 'hB4, 0);
        run_one("ror3",  1, 3, 'h96, 'hD2, 0);
        run_one("sll1",  2, 1, 'h96, 'h2C, 1);
        run_one("srl2",  3, 2, 'h96, 'h25, 1);
        run_one("sra2",  4, 2, 'h96, 'hE5, 1);
        run_one("srl7",  3, 7, 'h80, 'h01, 0);
        run_one("sll4z", 2, 4, 'h80, 'h00, 0);
        run_one("op6",   6, 5, 'h5A, 'h5A, 0);
        for (int op = 0; op < 8; op++) begin
            nr = int'($urandom_range(1, 255));
            run_one($sformatf("amt0 op%0d", op), op, 0, nr, nr, 0);
        end

        // Back-pressure: stream five operations and hold out_ready low for four cycles once the first result is valid.
        @(posedge clk);
        #1;
        for (int j = 0; j < 5; j++) begin
            rv = ref_op(8, bp_op[j], bp_amt[j], longint'(bp_num[j]));
            bp_exp[j] = rv[31:0];
        end
        n_in  = 0;
        n_out = 0;
        hold  = 0;
        seen  = 1'b0;
        for (int c = 0; c < 40 && n_out < 5; c++) begin
            if (t_out_valid[1]) seen = 1'b1;
            d_ready = !(seen && hold < 4);
            if (!d_ready) hold++;
            d_valid = (n_in < 5);
            if (n_in < 5) begin
                d_op  = 3'(bp_op[n_in]);
                d_amt = 3'(bp_amt[n_in]);
                d_num = bp_num[n_in];
            end
            #1;
            if (!d_ready) begin
                check("bp hold in_ready", t_in_ready[1], 0);
                check("bp hold out_valid", t_out_valid[1], 1);
                check("bp hold data", t_out_shifted[1], bp_exp[0]);
            end
            if (d_valid && t_in_ready[1]) n_in++;
            if (t_out_valid[1] && d_ready) begin
                bp_got[n_out] = t_out_shifted[1];
                n_out++;
            end
            @(posedge clk);
            #1;
        end
        d_valid = 1'b0;
        d_ready = 1'b1;
        check("bp result count", n_out, 5);
        check("bp hold cycles", hold, 4);
        for (int j = 0; j < 5; j++) check($sformatf("bp result %0d", j), bp_got[j], bp_exp[j]);

        // Reset while operations are in flight.
        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            d_valid = 1'b1;
            d_op    = 3'd0;
            d_amt   = 3'(j + 3);
            d_num   = 8'h96;
            @(posedge clk);
            #1;
        end
        d_valid = 1'b0;
        check("mid rst pre out_valid", t_out_valid[1], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst out_valid", t_out_valid[1], 0);
        check("mid rst out_shifted", t_out_shifted[1], 0);
        check("mid rst out_zero", t_out_zero[1], 1);
        check("mid rst out_carry", t_out_carry[1], 0);
        check("mid rst in_ready", t_in_ready[1], 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            check("post rst no stale", t_out_valid[1], 0);
            @(posedge clk);
            #1;
        end
        run_one("post rst sra", 4, 3, 'hA4, 'hF4, 1);

        // Randomised traffic on all three widths.
        @(posedge clk);
        #1;
        rnd_phase = 1'b1;
        repeat (850) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
